// File: rtl/fpu_mul_arb_pkg.sv
// Shared definitions for the multiplier arbiter: FSM state encoding and the operand width.
package fpu_mul_arb_pkg;

  localparam int SP_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESP    = 2'd2
  } state_e;

endpackage

// File: rtl/fpu_rr_arbiter.sv
// Combinational grant picker: round-robin from last_grant+1, or lowest-index-wins when
// FPU_MUL_ARB_FIXED_PRIO_EN is defined (the last_grant port then disappears).
module fpu_rr_arbiter
  import fpu_mul_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
`ifndef FPU_MUL_ARB_FIXED_PRIO_EN
  input  logic [ID_W-1:0]    last_grant,
`endif
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id
);

`ifndef FPU_MUL_ARB_FIXED_PRIO_EN
  int idx;
`endif

  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
`ifdef FPU_MUL_ARB_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_valid = 1'b1;
        gnt_id    = ID_W'(i);
      end
    end
`else
    idx = 0;
    // Offsets are walked backwards so the nearest requester after last_grant wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = ID_W'(idx);
      end
    end
`endif
  end

endmodule

// File: rtl/fpu_sp_multiplier.sv
// Combinational IEEE-754 single-precision multiplier, round-to-nearest-even,
// subnormal inputs and results flushed to signed zero.
module fpu_sp_multiplier (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] p
);

  logic        sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, guard, sticky;
  logic [7:0]  ea, eb;
  logic [47:0] prod;
  logic [22:0] mant;
  logic [23:0] mant_rnd;
  int          exp_v;

  assign sign   = a[31] ^ b[31];
  assign ea     = a[30:23];
  assign eb     = b[30:23];
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (a[22:0] == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (b[22:0] == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (a[22:0] != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (b[22:0] != 23'd0);
  assign prod   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});

  always_comb begin
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_v  = int'(ea) + int'(eb) - 126;
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
      exp_v  = int'(ea) + int'(eb) - 127;
    end
    mant_rnd = {1'b0, mant} + 24'(guard && (sticky || mant[0]));
    if (mant_rnd[23]) exp_v = exp_v + 1;

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) p = 32'h7FC00000;
    else if (a_inf || b_inf)                                      p = {sign, 8'hFF, 23'd0};
    else if (a_zero || b_zero)                                    p = {sign, 31'd0};
    else if (exp_v >= 255)                                        p = {sign, 8'hFF, 23'd0};
    else if (exp_v <= 0)                                          p = {sign, 31'd0};
    else                                                          p = {sign, 8'(exp_v), mant_rnd[22:0]};
  end

endmodule

// File: rtl/fpu_mul_arbiter.sv
// Shares one combinational single-precision multiplier between NUM_REQ requesters.
// Define FPU_MUL_ARB_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module fpu_mul_arbiter
  import fpu_mul_arb_pkg::*;
#(
  parameter int WIDTH      = SP_WIDTH,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int MUL_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     busy
);

  localparam int CNT_W = 4;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d, mul_p;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [ID_W-1:0]  id_q, id_d, rsp_id_q, rsp_id_d, gnt_id;
  logic             rsp_valid_q, rsp_valid_d, gnt_valid;
`ifndef FPU_MUL_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]  last_q, last_d;
`endif

  fpu_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req        (req_valid),
`ifndef FPU_MUL_ARB_FIXED_PRIO_EN
    .last_grant (last_q),
`endif
    .gnt_valid  (gnt_valid),
    .gnt_id     (gnt_id)
  );

  // Multiplier sees only the operand registers, so its inputs are quiet for MUL_CYCLES.
  fpu_sp_multiplier u_mul (
    .a (op_a_q),
    .b (op_b_q),
    .p (mul_p)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    req_ready    = '0;
`ifndef FPU_MUL_ARB_FIXED_PRIO_EN
    last_d       = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          req_ready[gnt_id] = 1'b1;
          op_a_d  = req_a[int'(gnt_id)*WIDTH +: WIDTH];
          op_b_d  = req_b[int'(gnt_id)*WIDTH +: WIDTH];
          id_d    = gnt_id;
          cnt_d   = CNT_W'(MUL_CYCLES - 1);
          state_d = COMPUTE;
`ifndef FPU_MUL_ARB_FIXED_PRIO_EN
          last_d  = gnt_id;
`endif
        end
      end
      COMPUTE: begin
        if (cnt_q == '0) begin
          rsp_result_d = mul_p;
          rsp_id_d     = id_q;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      id_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
`ifndef FPU_MUL_ARB_FIXED_PRIO_EN
      last_q       <= ID_W'(NUM_REQ - 1);
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
`ifndef FPU_MUL_ARB_FIXED_PRIO_EN
      last_q       <= last_d;
`endif
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: doc/fpu_mul_arbiter.md
Name: fpu_mul_arbiter

Overview:
Shares one fpu_sp_multiplier datapath between NUM_REQ independent requesters. Each requester has a valid/ready operand interface; the block arbitrates round-robin, latches the winning operands, and holds them stable on the combinational multiplier for MUL_CYCLES cycles (multicycle path). It then registers the product and returns it with the requester ID on a single valid/ready response port. Sits between FPU issue logic and the shared multiplier.

Parameters:
WIDTH, 32, operand/result width; only 32 supported (single precision)
NUM_REQ, 4, number of requesters, 2..8
ID_W, 2, response ID width; must equal clog2(NUM_REQ)
MUL_CYCLES, 2, cycles operands are held on the multiplier before result capture, 1..15

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  NUM_REQ  per-requester operand valid
req_ready  output  NUM_REQ  per-requester accept; at most one bit high
req_a  input  NUM_REQ*WIDTH  operand A; requester i at [i*WIDTH +: WIDTH]
req_b  input  NUM_REQ*WIDTH  operand B; same packing
rsp_valid  output  1  result valid
rsp_ready  input  1  consumer accepts result
rsp_id  output  ID_W  index of requester that owns the result
rsp_result  output  WIDTH  product
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync deassert handled externally): state=IDLE; rsp_valid=0; rsp_id=0; rsp_result=0; counter=0; operand registers=0; last-grant pointer=NUM_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, COMPUTE, RESP.
- IDLE: grant = first i with req_valid[i], searching from last_grant+1 with wrap. req_ready[grant]=1 combinationally; all other bits 0. If no valid, req_ready=0.
- IDLE handshake edge: latch req_a/req_b[grant] and the grant index; last_grant<=grant; counter<=MUL_CYCLES-1; go to COMPUTE.
- COMPUTE: req_ready=0. Multiplier inputs come only from the operand registers. If counter==0, capture multiplier output into rsp_result, rsp_id<=latched index, go to RESP. Otherwise decrement.
- RESP: rsp_valid=1; rsp_result and rsp_id are stable until the handshake; req_ready=0. On rsp_valid&&rsp_ready, go to IDLE and clear rsp_valid. No new grant occurs in the same cycle.
- Latency: rsp_valid rises exactly MUL_CYCLES clock edges after the accepting edge. Minimum issue interval is MUL_CYCLES+2 cycles.
- req_ready depends combinationally on req_valid. Requesters must not gate valid on ready. A requester may drop valid without a handshake; this has no side effect.
- Arithmetic and special-case behaviour are entirely those of fpu_sp_multiplier. This block never modifies the product.
- rsp_ready held low: the block stays in RESP indefinitely; all req_ready stay 0.
- Reset mid-operation: in-flight operation is discarded; no response is produced.
- Pointer wrap: after grant NUM_REQ-1, the search starts at 0.

Optional Feature:
FPU_MUL_ARB_FIXED_PRIO_EN
- Defined: fixed priority; the lowest-index valid requester always wins; last-grant pointer is not implemented.
- Undefined (default): round-robin as above. Ports, latency and handshake are identical in both builds.

Decomposition:
- Shared package/header fpu_mul_arb_pkg: state encodings (IDLE=2'd0, COMPUTE=2'd1, RESP=2'd2) and the WIDTH=32 constant.
- One natural sub-module: fpu_rr_arbiter. Combinational round-robin grant from a request vector and last-grant pointer; fixed-priority variant selected by the macro.
- fpu_sp_multiplier is instantiated unchanged.

Test Plan:
- Single op: req 0 sends 0x40000000 * 0x40400000, MUL_CYCLES=2, rsp_ready=1 -> rsp_valid 2 edges after accept; rsp_result=0x40C00000; rsp_id=0.
- Contention: all 4 valid continuously (1.5*1.5, i.e. 0x3FC00000 x2) -> grants in order 0,1,2,3,0; each rsp_result=0x40100000; issue interval 4 cycles. With FPU_MUL_ARB_FIXED_PRIO_EN -> grants 0,0,0.
- Backpressure: req 2 sends 0xC0000000 * 0x40800000, rsp_ready=0 for 10 cycles -> rsp_valid held; rsp_result=0xC1000000; rsp_id=2; req_ready=0 throughout; completes one cycle after rsp_ready=1.
- Reset mid-COMPUTE: assert rst_n=0 during COMPUTE -> rsp_valid=0 immediately; busy=0; no response after release; next grant goes to requester 0.
- Valid withdrawal: req 1 pulses valid while the block is in RESP, then drops it -> no grant to 1; only the pending response completes.
- MUL_CYCLES=1 build: single op as in the first scenario -> rsp_valid 1 edge after accept with the same result.
